// File: rtl/pipe_ctrl.sv
// Pipeline control for the 5-stage F/D/E/M/W ARM datapath.
// Carries decoder controls D->E->M->W, evaluates condition codes in E,
// owns the NZCV flags register, and produces the load-use stall,
// the taken-branch flush and the E-stage operand forward selects.
module pipe_ctrl #(
  parameter int unsigned   AW     = 4,
  parameter logic [AW-1:0] PC_REG = 4'hF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          RegWriteD,
  input  logic          MemWriteD,
  input  logic          MemtoRegD,
  input  logic          ALUSrcD,
  input  logic [1:0]    ALUControlD,
  input  logic [1:0]    FlagWriteD,
  input  logic          BranchD,
  input  logic [3:0]    CondD,
  input  logic [AW-1:0] RA1D,
  input  logic [AW-1:0] RA2D,
  input  logic [AW-1:0] WA3D,
  input  logic [3:0]    ALUFlagsE,
  output logic          ALUSrcE,
  output logic [1:0]    ALUControlE,
  output logic          BranchTakenE,
  output logic [1:0]    ForwardAE,
  output logic [1:0]    ForwardBE,
  output logic          MemWriteM,
  output logic          MemtoRegW,
  output logic          RegWriteW,
  output logic [AW-1:0] WA3W,
  output logic          StallF,
  output logic          StallD,
  output logic          FlushD
);

  typedef enum logic [3:0] {
    COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
    COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
    COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
    COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF
  } cond_e;

  typedef struct packed {
    logic          reg_write;
    logic          mem_write;
    logic          mem_to_reg;
    logic          alu_src;
    logic [1:0]    alu_control;
    logic [1:0]    flag_write;
    logic          branch;
    logic [3:0]    cond;
    logic [AW-1:0] ra1;
    logic [AW-1:0] ra2;
    logic [AW-1:0] wa3;
  } de_t;

  typedef struct packed {
    logic          reg_write;
    logic          mem_write;
    logic          mem_to_reg;
    logic [AW-1:0] wa3;
  } em_t;

  typedef struct packed {
    logic          reg_write;
    logic          mem_to_reg;
    logic [AW-1:0] wa3;
  } mw_t;

  de_t        de_d, de_q;
  em_t        em_d, em_q;
  mw_t        mw_d, mw_q;
  logic [3:0] flags_d, flags_q;

  logic       flag_n, flag_z, flag_c, flag_v;
  logic       cond_ex_e;
  logic       branch_taken_e;
  logic       ldr_stall;
  logic       flush_e;
  logic [1:0] fwd_a_e, fwd_b_e;

  // M has priority over W; the PC register is never forwarded.
  function automatic logic [1:0] fwd_sel(
    input logic [AW-1:0] ra,
    input logic          rw_m,
    input logic [AW-1:0] wa_m,
    input logic          rw_w,
    input logic [AW-1:0] wa_w
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (ra != PC_REG) begin
      if (rw_m && (wa_m == ra))      sel = 2'b10;
      else if (rw_w && (wa_w == ra)) sel = 2'b01;
    end
    return sel;
  endfunction

  // Condition check of the E instruction against the committed flags
  always_comb begin
    {flag_n, flag_z, flag_c, flag_v} = flags_q;
    cond_ex_e = 1'b0;
    case (cond_e'(de_q.cond))
      COND_EQ: cond_ex_e = flag_z;
      COND_NE: cond_ex_e = ~flag_z;
      COND_CS: cond_ex_e = flag_c;
      COND_CC: cond_ex_e = ~flag_c;
      COND_MI: cond_ex_e = flag_n;
      COND_PL: cond_ex_e = ~flag_n;
      COND_VS: cond_ex_e = flag_v;
      COND_VC: cond_ex_e = ~flag_v;
      COND_HI: cond_ex_e = flag_c & ~flag_z;
      COND_LS: cond_ex_e = ~flag_c | flag_z;
      COND_GE: cond_ex_e = (flag_n == flag_v);
      COND_LT: cond_ex_e = (flag_n != flag_v);
      COND_GT: cond_ex_e = ~flag_z & (flag_n == flag_v);
      COND_LE: cond_ex_e = flag_z | (flag_n != flag_v);
      COND_AL: cond_ex_e = 1'b1;
      default: cond_ex_e = 1'b0;
    endcase
  end

  // Hazard detection: load-use stall, branch flush, forward selects
  always_comb begin
    branch_taken_e = de_q.branch & cond_ex_e;
    ldr_stall      = de_q.mem_to_reg & de_q.reg_write &
                     ((RA1D == de_q.wa3) | (RA2D == de_q.wa3));
    flush_e        = ldr_stall | branch_taken_e;
    fwd_a_e        = fwd_sel(de_q.ra1, em_q.reg_write, em_q.wa3, mw_q.reg_write, mw_q.wa3);
    fwd_b_e        = fwd_sel(de_q.ra2, em_q.reg_write, em_q.wa3, mw_q.reg_write, mw_q.wa3);
  end

  // Next-state for the stage registers and the flags
  always_comb begin
    de_d = '{reg_write:   RegWriteD,
             mem_write:   MemWriteD,
             mem_to_reg:  MemtoRegD,
             alu_src:     ALUSrcD,
             alu_control: ALUControlD,
             flag_write:  FlagWriteD,
             branch:      BranchD,
             cond:        CondD,
             ra1:         RA1D,
             ra2:         RA2D,
             wa3:         WA3D};
    if (flush_e) de_d = '0;

    em_d = '{reg_write:  de_q.reg_write & cond_ex_e,
             mem_write:  de_q.mem_write & cond_ex_e,
             mem_to_reg: de_q.mem_to_reg,
             wa3:        de_q.wa3};

    mw_d = '{reg_write:  em_q.reg_write,
             mem_to_reg: em_q.mem_to_reg,
             wa3:        em_q.wa3};

    flags_d = flags_q;
    if (cond_ex_e) begin
      if (de_q.flag_write[1]) flags_d[3:2] = ALUFlagsE[3:2];
      if (de_q.flag_write[0]) flags_d[1:0] = ALUFlagsE[1:0];
    end
  end

  // Stage registers and flags, synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      de_q    <= '0;
      em_q    <= '0;
      mw_q    <= '0;
      flags_q <= '0;
    end else begin
      de_q    <= de_d;
      em_q    <= em_d;
      mw_q    <= mw_d;
      flags_q <= flags_d;
    end
  end

  // Outputs, held at zero while reset is asserted
  always_comb begin
    ALUSrcE      = 1'b0;
    ALUControlE  = '0;
    BranchTakenE = 1'b0;
    ForwardAE    = '0;
    ForwardBE    = '0;
    MemWriteM    = 1'b0;
    MemtoRegW    = 1'b0;
    RegWriteW    = 1'b0;
    WA3W         = '0;
    StallF       = 1'b0;
    StallD       = 1'b0;
    FlushD       = 1'b0;
    if (!reset) begin
      ALUSrcE      = de_q.alu_src;
      ALUControlE  = de_q.alu_control;
      BranchTakenE = branch_taken_e;
      ForwardAE    = fwd_a_e;
      ForwardBE    = fwd_b_e;
      MemWriteM    = em_q.mem_write;
      MemtoRegW    = mw_q.mem_to_reg;
      RegWriteW    = mw_q.reg_write;
      WA3W         = mw_q.wa3;
      StallF       = ldr_stall;
      StallD       = ldr_stall;
      FlushD       = branch_taken_e;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed testbench for pipe_ctrl: forwarding, load-use stall,
// conditional execution, branch flush and reset behaviour.
module tb_pipe_ctrl;

  localparam int unsigned AW = 4;
  localparam logic [3:0] C_EQ = 4'h0;
  localparam logic [3:0] C_NE = 4'h1;
  localparam logic [3:0] C_LT = 4'hB;
  localparam logic [3:0] C_AL = 4'hE;
  localparam logic [3:0] C_NV = 4'hF;

  logic          clk = 1'b0;
  logic          reset;
  logic          RegWriteD, MemWriteD, MemtoRegD, ALUSrcD, BranchD;
  logic [1:0]    ALUControlD, FlagWriteD;
  logic [3:0]    CondD;
  logic [AW-1:0] RA1D, RA2D, WA3D;
  logic [3:0]    ALUFlagsE;
  logic          ALUSrcE, BranchTakenE, MemWriteM, MemtoRegW, RegWriteW;
  logic          StallF, StallD, FlushD;
  logic [1:0]    ALUControlE, ForwardAE, ForwardBE;
  logic [AW-1:0] WA3W;
  logic [17:0]   outs;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.AW(AW), .PC_REG(4'hF)) dut (
    .clk(clk), .reset(reset),
    .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .MemtoRegD(MemtoRegD),
    .ALUSrcD(ALUSrcD), .ALUControlD(ALUControlD), .FlagWriteD(FlagWriteD),
    .BranchD(BranchD), .CondD(CondD), .RA1D(RA1D), .RA2D(RA2D), .WA3D(WA3D),
    .ALUFlagsE(ALUFlagsE),
    .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE), .BranchTakenE(BranchTakenE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .MemWriteM(MemWriteM),
    .MemtoRegW(MemtoRegW), .RegWriteW(RegWriteW), .WA3W(WA3W),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD)
  );

  assign outs = {ALUSrcE, ALUControlE, BranchTakenE, ForwardAE, ForwardBE,
                 MemWriteM, MemtoRegW, RegWriteW, WA3W, StallF, StallD, FlushD};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Present one decoded instruction on the D-stage inputs
  task automatic drv(input logic rw, input logic mw, input logic m2r, input logic als,
                     input logic [1:0] aluc, input logic [1:0] fw, input logic br,
                     input logic [3:0] cond, input logic [3:0] ra1, input logic [3:0] ra2,
                     input logic [3:0] wa3);
    RegWriteD = rw; MemWriteD = mw; MemtoRegD = m2r; ALUSrcD = als;
    ALUControlD = aluc; FlagWriteD = fw; BranchD = br; CondD = cond;
    RA1D = ra1; RA2D = ra2; WA3D = wa3;
  endtask

  task automatic nop();
    drv(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) begin
      nop();
      tick();
    end
  endtask

  initial begin
    ALUFlagsE = 4'h0;
    reset = 1'b1;
    // load in D while in reset: outputs must stay low
    drv(1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0, C_AL, 4'h1, 4'h1, 4'h1);
    #1; check("rst_outs0", 32'(outs), 0); tick();
    #1; check("rst_outs1", 32'(outs), 0); tick();
    reset = 1'b0;
    nop();
    #1; check("post_rst_outs", 32'(outs), 0);
    check("post_rst_flags", 32'(dut.flags_q), 0);
    tick();

    // 1a: ADD r1,r2,r3 ; SUB r4,r1,r5 -> forward from M
    drv(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, C_AL, 4'h2, 4'h3, 4'h1); tick();
    drv(1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0, C_AL, 4'h1, 4'h5, 4'h4); tick();
    nop(); #1;
    check("t1_fwdA_M", 32'(ForwardAE), 2);
    check("t1_fwdB_none", 32'(ForwardBE), 0);
    check("t1_aluctl", 32'(ALUControlE), 1);
    tick();
    nop(); #1;
    check("t1_rw_w", 32'(RegWriteW), 1);
    check("t1_wa3_w", 32'(WA3W), 1);
    tick();
    drain(3);

    // 1b: ADD r1 ; NOP ; SUB r4,r1,r1 -> forward from W on both operands
    drv(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, C_AL, 4'h2, 4'h3, 4'h1); tick();
    nop(); tick();
    drv(1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0, C_AL, 4'h1, 4'h1, 4'h4); tick();
    nop(); #1;
    check("t1_fwdA_W", 32'(ForwardAE), 1);
    check("t1_fwdB_W", 32'(ForwardBE), 1);
    tick();
    drain(3);

    // 1c: two writers of r1 back to back -> M wins over W
    drv(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, C_AL, 4'h2, 4'h3, 4'h1); tick();
    drv(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, C_AL, 4'h6, 4'h7, 4'h1); tick();
    drv(1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0, C_AL, 4'h1, 4'h5, 4'h4); tick();
    nop(); #1;
    check("t1_prio_M", 32'(ForwardAE), 2);
    tick();
    drain(3);

    // 1d: writer of r15 then reader of r15 -> never forwarded
    drv(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, C_AL, 4'h2, 4'h3, 4'hF); tick();
    drv(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, C_AL, 4'hF, 4'hF, 4'h4); tick();
    nop(); #1;
    check("t1_pc_fwdA", 32'(ForwardAE), 0);
    check("t1_pc_fwdB", 32'(ForwardBE), 0);
    tick();
    drain(3);

    // 2: LDR r1,[r0] ; ADD r2,r1,#imm -> one stall cycle, bubble, then W forward
    drv(1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0, C_AL, 4'h0, 4'h0, 4'h1); #1;
    check("t2_no_stall_pre", 32'(StallF), 0);
    tick();
    drv(1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, C_AL, 4'h1, 4'h3, 4'h2); #1;
    check("t2_stallF", 32'(StallF), 1);
    check("t2_stallD", 32'(StallD), 1);
    check("t2_flushD", 32'(FlushD), 0);
    tick();
    #1;
    check("t2_stall_once", 32'(StallF), 0);
    check("t2_bubble_alusrc", 32'(ALUSrcE), 0);
    tick();
    nop(); #1;
    check("t2_fwdA_W", 32'(ForwardAE), 1);
    check("t2_m2r_w", 32'(MemtoRegW), 1);
    check("t2_add_in_E", 32'(ALUSrcE), 1);
    tick();
    drain(3);

    // 3: CMP r0,r0 sets Z,C ; ADDNE r1 is squashed
    drv(1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b11, 1'b0, C_AL, 4'h0, 4'h0, 4'h0); tick();
    drv(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, C_NE, 4'h2, 4'h3, 4'h1);
    ALUFlagsE = 4'b0110; tick();
    nop(); ALUFlagsE = 4'b1001; #1;
    check("t3_flags", 32'(dut.flags_q), 32'h6);
    tick();
    nop(); ALUFlagsE = 4'h0; tick();
    #1;
    check("t3_rw_w_gated", 32'(RegWriteW), 0);
    check("t3_wa3_w", 32'(WA3W), 1);
    tick();
    drain(2);

    // 4a: BEQ with Z=1 -> taken, D flushed, E bubble, follower never writes back
    drv(1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b1, C_EQ, 4'h0, 4'h0, 4'h0); tick();
    drv(1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 1'b0, C_AL, 4'h2, 4'h3, 4'h7); #1;
    check("t4_taken", 32'(BranchTakenE), 1);
    check("t4_flushD", 32'(FlushD), 1);
    tick();
    nop(); #1;
    check("t4_taken_once", 32'(BranchTakenE), 0);
    check("t4_flushD_once", 32'(FlushD), 0);
    check("t4_bubble_alusrc", 32'(ALUSrcE), 0);
    check("t4_bubble_aluctl", 32'(ALUControlE), 0);
    tick();
    nop(); tick();
    #1;
    check("t4_no_wb", 32'(RegWriteW), 0);
    tick();

    // 4b: update only N,Z (Z cleared, N set) ; BEQ not taken ; BLT taken
    drv(1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b10, 1'b0, C_AL, 4'h0, 4'h0, 4'h0); tick();
    drv(1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b1, C_EQ, 4'h0, 4'h0, 4'h0);
    ALUFlagsE = 4'b1011; tick();
    drv(1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 1'b0, C_AL, 4'h2, 4'h3, 4'h7);
    ALUFlagsE = 4'h0; #1;
    check("t4_flags_nz_only", 32'(dut.flags_q), 32'hA);
    check("t4_nt_taken", 32'(BranchTakenE), 0);
    check("t4_nt_flushD", 32'(FlushD), 0);
    tick();
    drv(1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b1, C_LT, 4'h0, 4'h0, 4'h0); #1;
    check("t4_nt_follower", 32'(ALUControlE), 2);
    tick();
    nop(); #1;
    check("t4_lt_taken", 32'(BranchTakenE), 1);
    tick();
    drain(3);

    // Load-use and taken branch in the same cycle: E bubble wins, F/D hold
    drv(1'b1, 1'b0, 1'b1, 1'b0, 2'b11, 2'b00, 1'b1, C_AL, 4'h0, 4'h0, 4'h1); tick();
    drv(1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 1'b0, C_AL, 4'h1, 4'h3, 4'h2); #1;
    check("tc_stallF", 32'(StallF), 1);
    check("tc_flushD", 32'(FlushD), 1);
    tick();
    #1;
    check("tc_flush_wins", 32'(ALUControlE), 0);
    check("tc_stall_once", 32'(StallF), 0);
    tick();
    drain(3);

    // 5: STR AL reaches M, STR NV does not, reset kills STR in E
    drv(1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, C_AL, 4'h0, 4'h1, 4'h0); tick();
    nop(); tick();
    #1;
    check("t5_str_al", 32'(MemWriteM), 1);
    tick();
    drv(1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, C_NV, 4'h0, 4'h1, 4'h0); tick();
    nop(); tick();
    #1;
    check("t5_str_nv", 32'(MemWriteM), 0);
    tick();
    drv(1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, C_AL, 4'h0, 4'h1, 4'h0); tick();
    nop(); reset = 1'b1; #1;
    check("t5_rst_gate", 32'(outs), 0);
    tick();
    reset = 1'b0; #1;
    check("t5_rst_str", 32'(MemWriteM), 0);
    check("t5_rst_outs", 32'(outs), 0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
